// File: rtl/operand_stage.sv
// Operand-fetch stage: 8x16 register file, two sequential reads into A/B latches, B shifter and
// source selects, valid/ready hand-off to the ALU. Optional write-first collision: OPERAND_BYPASS_EN.
module operand_stage #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [1:0]       op_in,
  input  logic             wb_en,
  input  logic [2:0]       wb_reg,
  input  logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] bin,
  output logic [1:0]       aluop,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, VALID} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cmd_rn_q, cmd_rm_q;
  logic [1:0]       cmd_shift_q, cmd_op_q;
  logic             cmd_asel_q, cmd_bsel_q;
  logic [WIDTH-1:0] cmd_imm_q;
  logic [2:0]       rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] b_shifted;

  // Handshake: a transfer happens on the rising edge where out_valid && out_ready; out_valid
  // only rises in VALID and holds, with ain/bin/aluop stable, until that edge (or reset).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = VALID;
      VALID:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single read port: index follows the load state.
  always_comb begin
    rd_idx  = (state_q == LOAD_A) ? cmd_rn_q : cmd_rm_q;
    rd_data = rf_q[rd_idx];
`ifdef OPERAND_BYPASS_EN
    if (wb_en && (wb_reg == rd_idx)) rd_data = wb_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cmd_rn_q    <= '0;
      cmd_rm_q    <= '0;
      cmd_shift_q <= '0;
      cmd_op_q    <= '0;
      cmd_asel_q  <= 1'b0;
      cmd_bsel_q  <= 1'b0;
      cmd_imm_q   <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cmd_rn_q    <= rn;
        cmd_rm_q    <= rm;
        cmd_shift_q <= shift;
        cmd_op_q    <= op_in;
        cmd_asel_q  <= asel;
        cmd_bsel_q  <= bsel;
        cmd_imm_q   <= sximm5;
      end
      if (state_q == LOAD_A) a_q <= rd_data;
      if (state_q == LOAD_B) b_q <= rd_data;
      if (wb_en) rf_q[wb_reg] <= wb_data;
    end
  end

  always_comb begin
    b_shifted = b_q;
    case (cmd_shift_q)
      2'b01:   b_shifted = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == VALID);
    ain       = '0;
    bin       = '0;
    aluop     = '0;
    if (state_q == VALID) begin
      ain   = cmd_asel_q ? '0 : a_q;
      bin   = cmd_bsel_q ? cmd_imm_q : b_shifted;
      aluop = cmd_op_q;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: latency, shifter, selects, stall/hold, write-back collision
// and mid-operation reset, with hand-computed expectations.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset, start, asel, bsel, wb_en, out_ready;
  logic [2:0]  rn, rm, wb_reg;
  logic [1:0]  shift, op_in;
  logic [15:0] sximm5, wb_data;
  logic        busy, out_valid;
  logic [15:0] ain, bin;
  logic [1:0]  aluop, state_dbg;

  int total = 0;
  int bad   = 0;

  operand_stage dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .shift(shift),
    .asel(asel), .bsel(bsel), .sximm5(sximm5), .op_in(op_in), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .ain(ain), .bin(bin), .aluop(aluop), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  {15'd0, busy}, 16'h0);
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'h0);
    chk({tag, "_ain"},   ain, 16'h0);
    chk({tag, "_bin"},   bin, 16'h0);
    chk({tag, "_aluop"}, {14'd0, aluop}, 16'h0);
    chk({tag, "_state"}, {14'd0, state_dbg}, 16'h0);
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                       input logic as, input logic bs, input logic [15:0] imm,
                       input logic [1:0] op);
    start = 1'b1; rn = a; rm = b; shift = sh; asel = as; bsel = bs; sximm5 = imm; op_in = op;
    step();
    start = 1'b0;
  endtask

  // Full command with out_ready high: checks latency, operands, and busy drop.
  task automatic run_cmd(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] sh, input logic as, input logic bs,
                         input logic [15:0] imm, input logic [1:0] op,
                         input logic [15:0] ea, input logic [15:0] eb);
    out_ready = 1'b1;
    issue(a, b, sh, as, bs, imm, op);
    chk({tag, "_lda_valid"}, {15'd0, out_valid}, 16'h0);
    chk({tag, "_lda_busy"},  {15'd0, busy}, 16'h1);
    step();
    chk({tag, "_ldb_valid"}, {15'd0, out_valid}, 16'h0);
    step();
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'h1);
    chk({tag, "_ain"},   ain, ea);
    chk({tag, "_bin"},   bin, eb);
    chk({tag, "_aluop"}, {14'd0, aluop}, {14'd0, op});
    step();
    chk({tag, "_busy_drop"}, {15'd0, busy}, 16'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; asel = 1'b0; bsel = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    rn = '0; rm = '0; wb_reg = '0; shift = '0; op_in = '0; sximm5 = '0; wb_data = '0;
    step(); step();
    reset = 1'b0;
    chk_idle("reset");

    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0003);
    run_cmd("basic", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, 16'h0005, 16'h0003);

    wr(3'd3, 16'h8001);
    run_cmd("lsl1", 3'd1, 3'd3, 2'b01, 1'b0, 1'b0, 16'h0, 2'b10, 16'h0005, 16'h0002);
    run_cmd("lsr1", 3'd3, 3'd3, 2'b10, 1'b0, 1'b0, 16'h0, 2'b11, 16'h8001, 16'h4000);
    run_cmd("asr1", 3'd2, 3'd3, 2'b11, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0003, 16'hC000);

    wr(3'd0, 16'h1234);
    run_cmd("sel", 3'd0, 3'd0, 2'b01, 1'b1, 1'b1, 16'hFFF0, 2'b01, 16'h0000, 16'hFFF0);

    // Stall in VALID; a start pulse with different fields must not disturb anything.
    out_ready = 1'b0;
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b10);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {15'd0, out_valid}, 16'h1);
      chk("hold_ain", ain, 16'h0005);
      chk("hold_bin", bin, 16'h0003);
      chk("hold_aluop", {14'd0, aluop}, 16'h2);
      if (i == 2) begin
        start = 1'b1; rn = 3'd3; rm = 3'd0; shift = 2'b11; asel = 1'b1; bsel = 1'b1;
        sximm5 = 16'hBEEF; op_in = 2'b11;
      end
      step();
      start = 1'b0;
    end
    chk("hold_after_ain", ain, 16'h0005);
    chk("hold_after_bin", bin, 16'h0003);
    out_ready = 1'b1;
    step();
    chk("release_busy", {15'd0, busy}, 16'h0);
    chk("release_valid", {15'd0, out_valid}, 16'h0);

    // Write-back colliding with the B read in LOAD_B.
    wr(3'd4, 16'h0011);
    issue(3'd1, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
    step();
    chk("coll_in_ldb", {14'd0, state_dbg}, 16'h2);
    wb_en = 1'b1; wb_reg = 3'd4; wb_data = 16'h00AA;
    step();
    wb_en = 1'b0;
`ifdef OPERAND_BYPASS_EN
    chk("coll_bin", bin, 16'h00AA);
`else
    chk("coll_bin", bin, 16'h0011);
`endif
    chk("coll_ain", ain, 16'h0005);
    step();
    run_cmd("coll_next", 3'd4, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, 16'h00AA, 16'h00AA);

    // Reset in LOAD_A with a simultaneous write and start, which reset must override.
    wr(3'd5, 16'h5555);
    issue(3'd5, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0, 2'b11);
    chk("mid_in_lda", {14'd0, state_dbg}, 16'h1);
    reset = 1'b1; wb_en = 1'b1; wb_reg = 3'd6; wb_data = 16'hFFFF; start = 1'b1;
    step();
    reset = 1'b0; wb_en = 1'b0; start = 1'b0;
    chk_idle("mid_reset");
    run_cmd("rb01", 3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 16'h0);
    run_cmd("rb23", 3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 16'h0);
    run_cmd("rb45", 3'd4, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 16'h0);
    run_cmd("rb67", 3'd6, 3'd7, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
